// File: rtl/sample_streamer.sv
// Buffered sample streamer: loads words into an internal buffer, then plays them out
// as timed strobes. Define SAMPLE_STREAMER_LOOP_EN to enable looped playback.

module sample_streamer_lane #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge rst)
    if (!rst)    q <= '0;
    else if (ld) q <= d;
endmodule

module sample_streamer #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 1,
  parameter int DEPTH    = 9000,
  localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wrEn,
  input  logic [AW-1:0]             wrAddr,
  input  logic [CHANNELS*WIDTH-1:0] wrData,
  input  logic                      start,
  input  logic                      abort,
  input  logic [AW:0]               length,
  input  logic [15:0]               interval,
  input  logic                      loop,
  input  logic                      consumerBusy,
  output logic [CHANNELS*WIDTH-1:0] inputSample,
  output logic                      sampleReady,
  output logic                      running,
  output logic                      done,
  output logic [31:0]               sampleCount
);

  typedef enum logic [2:0] {IDLE, FETCH, EMIT, GAP, DONE} state_t;

  state_t state, state_n;

  logic [CHANNELS-1:0][WIDTH-1:0] mem [DEPTH];
  logic [CHANNELS-1:0][WIDTH-1:0] rd_word;

  logic [AW-1:0] addr, next_addr;
  logic [AW:0]   len_q;
  logic [15:0]   ivl_q, ivl_eff, gcnt;
  logic [31:0]   cnt;
  logic          loop_q;
  logic          go, rd, last, gap_end, wr_ok;

  // Buffer has no reset so contents survive rst.
  assign wr_ok = wrEn && (state == IDLE || state == DONE) && (int'(wrAddr) < DEPTH);

  always_ff @(posedge clk)
    if (wr_ok) mem[wrAddr] <= wrData;

  assign rd_word = mem[addr];
  assign last    = ({1'b0, addr} == len_q - 1'b1);
  assign gap_end = (gcnt == '0);
  assign ivl_eff = (ivl_q == '0) ? 16'd1 : ivl_q;

`ifdef SAMPLE_STREAMER_LOOP_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst)    loop_q <= 1'b0;
    else if (go) loop_q <= loop;

  assign next_addr = last ? '0 : addr + 1'b1;
`else
  logic unused_loop;
  assign unused_loop = loop;
  assign loop_q      = 1'b0;
  assign next_addr   = addr + 1'b1;
`endif

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= state_n;

  // rd is the buffer read; it lands in the output lanes as the FSM enters EMIT.
  always_comb begin
    state_n = state;
    go      = 1'b0;
    rd      = 1'b0;
    case (state)
      IDLE, DONE:
        if (start && !abort) begin
          go      = 1'b1;
          state_n = (length == '0) ? DONE : FETCH;
        end
      FETCH: begin
        rd      = 1'b1;
        state_n = EMIT;
      end
      EMIT:  state_n = (last && !loop_q) ? DONE : GAP;
      GAP:
        if (gap_end && !consumerBusy) begin
          rd      = 1'b1;
          state_n = EMIT;
        end
      default: state_n = IDLE;
    endcase
    if (abort && state != IDLE) begin
      state_n = IDLE;
      go      = 1'b0;
      rd      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      addr        <= '0;
      len_q       <= '0;
      ivl_q       <= '0;
      gcnt        <= '0;
      cnt         <= '0;
      sampleReady <= 1'b0;
    end else begin
      sampleReady <= rd;
      if (go) begin
        addr  <= '0;
        len_q <= length;
        ivl_q <= interval;
        cnt   <= '0;
      end else begin
        if (rd && cnt != '1) cnt <= cnt + 32'd1;
        // GAP runs ivl_eff cycles; the last one doubles as the prefetch cycle.
        if (state == EMIT) begin
          gcnt <= ivl_eff - 16'd1;
          addr <= next_addr;
        end else if (state == GAP && !gap_end) begin
          gcnt <= gcnt - 16'd1;
        end
      end
    end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    sample_streamer_lane #(.WIDTH(WIDTH)) u_lane (
      .clk (clk),
      .rst (rst),
      .ld  (rd),
      .d   (rd_word[i]),
      .q   (inputSample[i*WIDTH +: WIDTH])
    );
  end

  assign running     = (state == FETCH) || (state == EMIT) || (state == GAP);
  assign done        = (state == DONE);
  assign sampleCount = cnt;

endmodule

// File: tb/tb_sample_streamer.sv
// Scoreboard bench for sample_streamer: a cycle-level strobe schedule is predicted per pass
// and a negedge monitor checks every strobe and that the output holds in between.

module tb_sample_streamer;
  localparam int WIDTH = 16, CHANNELS = 2, DEPTH = 64, AW = 6, DW = WIDTH*CHANNELS;
`ifdef SAMPLE_STREAMER_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1, wrEn = 1'b0, start = 1'b0, abort = 1'b0;
  logic loop = 1'b0, consumerBusy = 1'b0;
  logic [AW-1:0]  wrAddr = '0;
  logic [DW-1:0]  wrData = '0;
  logic [AW:0]    length = '0;
  logic [15:0]    interval = '0;
  logic [DW-1:0]  inputSample;
  logic           sampleReady, running, done;
  logic [31:0]    sampleCount;

  sample_streamer #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
    .start(start), .abort(abort), .length(length), .interval(interval), .loop(loop),
    .consumerBusy(consumerBusy), .inputSample(inputSample), .sampleReady(sampleReady),
    .running(running), .done(done), .sampleCount(sampleCount)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0, nerr = 0;
  int bb0 = 0, bb1 = 0;

  typedef struct { logic [DW-1:0] data; int t; int cnt; } exp_t;
  exp_t expq[$];
  logic [DW-1:0] bufm [DEPTH];
  logic [DW-1:0] last_out = '0;

  // consumerBusy value driven at negedge of cycle c is what the DUT sees for cycle c
  always @(negedge clk) consumerBusy = (cyc >= bb0 && cyc < bb1);

  always @(negedge clk or negedge rst) begin
    exp_t e;
    if (!rst) last_out = '0;
    else if (sampleReady) begin
      nvec++;
      if (expq.size() == 0) begin
        nerr++;
        $display("FAIL strobe: unexpected strobe at cycle %0d data %h", cyc, inputSample);
      end else begin
        e = expq.pop_front();
        if (inputSample !== e.data || cyc != e.t || sampleCount !== 32'(e.cnt)) begin
          nerr++;
          $display("FAIL strobe: got data %h cycle %0d count %0d, want data %h cycle %0d count %0d",
                   inputSample, cyc, sampleCount, e.data, e.t, e.cnt);
        end
      end
      last_out = inputSample;
    end else begin
      nvec++;
      if (inputSample !== last_out) begin
        nerr++;
        $display("FAIL hold: inputSample %h, want %h", inputSample, last_out);
        last_out = inputSample;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    @(negedge clk);
    wrEn = 1'b1; wrAddr = a[AW-1:0]; wrData = d;
    bufm[a] = d;
    @(negedge clk);
    wrEn = 1'b0;
  endtask

  // One pass: predict strobes (data, cycle, count) from the playback rules, then drive.
  // b0/b1: busy window relative to start cycle; arel>0: abort (kind=0) or reset (kind=1) there.
  task automatic run(input int len, input int ivl, input bit lp, input int b0, input int b1,
                     input int arel, input bit kind, input bit junk);
    int S, A, ie, t, c, k, endc;
    bit lpe;
    exp_t e;
    @(negedge clk);
    S = cyc;
    start = 1'b1; length = len[AW:0]; interval = ivl[15:0]; loop = lp;
    bb0 = S + b0; bb1 = S + b1;
    ie  = (ivl == 0) ? 1 : ivl;
    lpe = LOOP_EN && lp;
    A   = (arel > 0) ? S + arel : 32'h3fffffff;
    endc = S + 1; t = S + 2; k = 0;
    while (len > 0 && t <= A && (lpe || k < len)) begin
      e.data = bufm[k % len]; e.t = t; e.cnt = k + 1;
      expq.push_back(e);
      k++; endc = t + 1;
      c = t + ie;
      while (c >= bb0 && c < bb1) c++;
      t = c + 1;
    end
    if (arel > 0) endc = A + 1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < endc) begin
      if (cyc == S + 1) chk("running", 64'(running), 64'(len > 0));
      if (junk && cyc == S + 3) begin wrEn = 1'b1; wrAddr = 6'd1; wrData = $urandom; end
      if (cyc == A) begin
        if (kind) begin
          #1 rst = 1'b0;
          #1;
          chk("rst sampleReady", 64'(sampleReady), 64'd0);
          chk("rst inputSample", 64'(inputSample), 64'd0);
          chk("rst running", 64'(running), 64'd0);
          chk("rst done", 64'(done), 64'd0);
          chk("rst sampleCount", 64'(sampleCount), 64'd0);
        end else abort = 1'b1;
      end
      @(negedge clk);
      wrEn = 1'b0; abort = 1'b0; rst = 1'b1;
    end
    chk("done", 64'(done), 64'(arel == 0));
    chk("running end", 64'(running), 64'd0);
    chk("sampleCount", 64'(sampleCount), kind ? 64'd0 : 64'(k));
    chk("queue drained", 64'(expq.size()), 64'd0);
    expq.delete();
    bb0 = 0; bb1 = 0;
    repeat (ie + 3) @(negedge clk);
  endtask

  initial begin
    #1 rst = 1'b0;
    #2;
    chk("reset sampleReady", 64'(sampleReady), 64'd0);
    chk("reset inputSample", 64'(inputSample), 64'd0);
    chk("reset running", 64'(running), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset sampleCount", 64'(sampleCount), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    for (int a = 0; a < DEPTH; a++)
      wr(a, (a < 5) ? {16'($urandom), 16'(a + 1)} : DW'($urandom));

    run(5, 250, 1'b0, 0, 0, 0, 1'b0, 1'b0);
    run(5, 0,   1'b0, 0, 0, 0, 1'b0, 1'b0);
    run(5, 1,   1'b0, 0, 0, 0, 1'b0, 1'b0);
    run(5, 10,  1'b0, 5, 45, 0, 1'b0, 1'b0);
    run(3, 4,   1'b1, 0, 0, 28, 1'b0, 1'b0);
    run(5, 6,   1'b0, 0, 0, 12, 1'b0, 1'b0);
    run(0, 7,   1'b0, 0, 0, 0, 1'b0, 1'b0);
    run(5, 3,   1'b0, 0, 0, 0, 1'b0, 1'b1);
    run(5, 6,   1'b0, 0, 0, 12, 1'b1, 1'b0);
    run(5, 2,   1'b0, 0, 0, 0, 1'b0, 1'b0);

    for (int r = 0; r < 10; r++) begin
      int n, iv, a, b0, b1;
      bit lp;
      repeat (3) wr($urandom_range(0, DEPTH - 1), DW'($urandom));
      n  = $urandom_range(1, 12);
      iv = $urandom_range(0, 5);
      lp = 1'($urandom_range(0, 1));
      a  = (lp || $urandom_range(0, 3) == 0) ? $urandom_range(1, 60) : 0;
      b0 = $urandom_range(3, 20);
      b1 = b0 + $urandom_range(0, 30);
      run(n, iv, lp, b0, b1, a, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
